// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB controller with memory wait timeout and sticky error flags
module multicycle_control_unit #(
    parameter int OPCODE_W = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                equal,
    input  logic                less,
    input  logic                greater,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_we,
    output logic                pc_we,
    output logic                reg_write,
    output logic                imm_sel,
    output logic [1:0]          alu_op,
    output logic                mem_to_reg,
    output logic                jump,
    output logic                branch_taken,
    output logic                illegal_op,
    output logic                timeout_err,
    output logic [2:0]          state
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERROR  = 3'd7
    } state_t;

    state_t              cur, nxt;
    logic [OPCODE_W-1:0] op_q;
    logic [7:0]          wait_cnt;
    logic [3:0]          op;
    logic                is_alu, is_ld, is_st, bad_op, waiting, expired;

    assign op      = op_q[3:0];
    assign is_alu  = ~op[3];
    assign is_ld   = op == 4'h9;
    assign is_st   = op == 4'hA;
    assign bad_op  = 32'(opcode) > 32'd15;
    assign waiting = cur == FETCH || cur == MEM;
    assign expired = ~mem_ready && wait_cnt == 8'(TIMEOUT - 1);
    assign state   = cur;

    // state register, opcode latch, wait counter and sticky error flags
    always_ff @(posedge clock) begin
        if (reset) begin
            cur         <= FETCH;
            op_q        <= '0;
            wait_cnt    <= '0;
            illegal_op  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cur      <= nxt;
            op_q     <= (cur == DECODE) ? opcode : op_q;
            wait_cnt <= (nxt != cur) ? 8'd0 : (waiting && !mem_ready) ? wait_cnt + 8'd1 : wait_cnt;
            if (cur == DECODE && bad_op)
                illegal_op <= 1'b1;
            if (waiting && expired)
                timeout_err <= 1'b1;
        end
    end

    // next-state and strobe decode from the current state and latched opcode
    always_comb begin
        nxt          = cur;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        reg_write    = 1'b0;
        imm_sel      = 1'b0;
        alu_op       = 2'b00;
        mem_to_reg   = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        case (cur)
            FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                nxt     = mem_ready ? DECODE : expired ? ERROR : FETCH;
            end
            DECODE: nxt = bad_op ? ERROR : EXEC;
            EXEC: begin
                if (is_alu) begin
                    alu_op  = op[2:1];
                    imm_sel = op[0];
                    nxt     = WB;
                end else if (is_ld || is_st) begin
                    imm_sel = 1'b1;
                    nxt     = MEM;
                end else if (op == 4'h8) begin
                    jump  = 1'b1;
                    pc_we = 1'b1;
                    nxt   = FETCH;
                end else begin
                    branch_taken = (op == 4'hB) ? equal :
                                   (op == 4'hC) ? less :
                                   (op == 4'hD) ? greater :
                                   (op == 4'hE) ? (equal | less) : (equal | greater);
                    pc_we = 1'b1;
                    nxt   = FETCH;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = is_st;
                pc_we   = mem_ready && is_st;
                nxt     = mem_ready ? (is_st ? FETCH : WB) : expired ? ERROR : MEM;
            end
            WB: begin
                pc_we      = 1'b1;
                reg_write  = is_alu | is_ld;
                mem_to_reg = is_ld;
                alu_op     = is_alu ? op[2:1] : 2'b00;
                imm_sel    = is_alu & op[0];
                nxt        = FETCH;
            end
            default: nxt = ERROR;
        endcase
        if (reset)
            {mem_req, mem_we, ir_we, pc_we, reg_write, imm_sel, alu_op, mem_to_reg, jump, branch_taken} = '0;
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed cycle-by-cycle checks of the multicycle controller
module tb_multicycle_control_unit;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rst_req = 1'b1;
    logic [4:0] opcode = '0;
    logic       equal = 1'b0, less = 1'b0, greater = 1'b0, mem_ready = 1'b0;
    logic       mem_req, mem_we, ir_we, pc_we, reg_write, imm_sel, mem_to_reg, jump, branch_taken, illegal_op, timeout_err;
    logic [1:0] alu_op;
    logic [2:0] state;
    logic [15:0] obs;
    int n_cmp = 0;
    int n_bad = 0;

    // packed view: state | mem_req mem_we ir_we pc_we reg_write imm_sel | alu_op | mem_to_reg jump branch_taken illegal_op timeout_err
    localparam logic [15:0] RST_OUT    = 16'b000_000000_00_00000;
    localparam logic [15:0] FETCH_RDY  = 16'b000_101000_00_00000;
    localparam logic [15:0] FETCH_WAIT = 16'b000_100000_00_00000;
    localparam logic [15:0] DEC        = 16'b001_000000_00_00000;
    localparam logic [15:0] EXEC_ADDR  = 16'b010_000001_00_00000;
    localparam logic [15:0] LD_MEM     = 16'b011_100000_00_00000;
    localparam logic [15:0] ST_WAIT    = 16'b011_110000_00_00000;
    localparam logic [15:0] ST_DONE    = 16'b011_110100_00_00000;
    localparam logic [15:0] LD_WB      = 16'b100_000110_00_10000;
    localparam logic [15:0] JUMP_EX    = 16'b010_000100_00_01000;
    localparam logic [15:0] ERR_TO     = 16'b111_000000_00_00001;
    localparam logic [15:0] ERR_ILL    = 16'b111_000000_00_00010;
    localparam logic [15:0] ST_ABORT   = 16'b011_000000_00_00000;

    assign obs = {state, mem_req, mem_we, ir_we, pc_we, reg_write, imm_sel, alu_op, mem_to_reg, jump, branch_taken, illegal_op, timeout_err};

    multicycle_control_unit #(.OPCODE_W(5), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .opcode(opcode),
        .equal(equal), .less(less), .greater(greater), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
        .reg_write(reg_write), .imm_sel(imm_sel), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
        .jump(jump), .branch_taken(branch_taken), .illegal_op(illegal_op),
        .timeout_err(timeout_err), .state(state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // one clock cycle: inputs change on the falling edge, outputs sampled 1 ns later
    task automatic cyc(input logic rdy);
        @(negedge clock);
        reset = rst_req;
        mem_ready = rdy;
        #1;
    endtask

    task automatic run_alu(input logic [3:0] op, input logic imm, input logic [1:0] a);
        opcode = {1'b0, op};
        cyc(1'b1); check($sformatf("alu%0h_fetch", op), obs, FETCH_RDY);
        cyc(1'b1); check($sformatf("alu%0h_decode", op), obs, DEC);
        cyc(1'b1); check($sformatf("alu%0h_exec", op), obs, {3'b010, 5'b00000, imm, a, 5'b00000});
        opcode = 5'h08;
        cyc(1'b1); check($sformatf("alu%0h_wb", op), obs, {3'b100, 5'b00011, imm, a, 5'b00000});
    endtask

    task automatic run_mem(input logic st, input int fw, input int mw);
        opcode = st ? 5'h0A : 5'h09;
        repeat (fw) begin cyc(1'b0); check("mem_fetch_wait", obs, FETCH_WAIT); end
        cyc(1'b1); check("mem_fetch", obs, FETCH_RDY);
        cyc(1'b1); check("mem_decode", obs, DEC);
        cyc(1'b1); check("mem_exec", obs, EXEC_ADDR);
        repeat (mw) begin cyc(1'b0); check("mem_wait", obs, st ? ST_WAIT : LD_MEM); end
        cyc(1'b1); check("mem_done", obs, st ? ST_DONE : LD_MEM);
        if (!st) begin cyc(1'b1); check("ld_wb", obs, LD_WB); end
    endtask

    initial begin
        logic [2:0] tk [5] = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b101};
        logic [2:0] pat;
        mem_ready = 1'b1;
        cyc(1'b1); check("rst_hold", obs, RST_OUT);
        rst_req = 1'b0;
        run_alu(4'h1, 1'b1, 2'b00);
        run_alu(4'h0, 1'b0, 2'b00);
        run_alu(4'h2, 1'b0, 2'b01);
        run_alu(4'h3, 1'b1, 2'b01);
        run_alu(4'h4, 1'b0, 2'b10);
        run_alu(4'h5, 1'b1, 2'b10);
        run_alu(4'h6, 1'b0, 2'b11);
        run_alu(4'h7, 1'b1, 2'b11);
        run_mem(1'b0, 3, 3);
        run_mem(1'b1, 0, 3);
        run_mem(1'b0, 0, 0);
        opcode = 5'h08;
        cyc(1'b1); check("jmp_fetch", obs, FETCH_RDY);
        cyc(1'b1); check("jmp_decode", obs, DEC);
        cyc(1'b1); check("jmp_exec", obs, JUMP_EX);
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 3; j++) begin
                pat = 3'b100 >> j;
                opcode = 5'(11 + i);
                {equal, less, greater} = 3'b111;
                cyc(1'b1); check("br_fetch", obs, FETCH_RDY);
                cyc(1'b1); check("br_decode", obs, DEC);
                {equal, less, greater} = pat;
                cyc(1'b1);
                check($sformatf("br%0h_%b", 11 + i, pat), obs, {3'b010, 6'b000100, 2'b00, 2'b00, tk[i][2-j], 2'b00});
            end
        end
        {equal, less, greater} = 3'b000;
        opcode = 5'h00;
        repeat (4) begin cyc(1'b0); check("to_fetch_wait", obs, FETCH_WAIT); end
        cyc(1'b1); check("to_error", obs, ERR_TO);
        cyc(1'b0); check("to_hold", obs, ERR_TO);
        rst_req = 1'b1;
        cyc(1'b1); check("to_rst_cycle", obs, ERR_TO);
        rst_req = 1'b0;
        repeat (3) begin cyc(1'b0); check("edge_wait", obs, FETCH_WAIT); end
        cyc(1'b1); check("edge_ready", obs, FETCH_RDY);
        opcode = 5'h12;
        cyc(1'b1); check("ill_decode", obs, DEC);
        cyc(1'b1); check("ill_error", obs, ERR_ILL);
        cyc(1'b1); check("ill_hold", obs, ERR_ILL);
        rst_req = 1'b1;
        cyc(1'b1); check("ill_rst_cycle", obs, ERR_ILL);
        rst_req = 1'b0;
        opcode = 5'h09;
        cyc(1'b1); check("ldto_fetch", obs, FETCH_RDY);
        cyc(1'b1); check("ldto_decode", obs, DEC);
        cyc(1'b1); check("ldto_exec", obs, EXEC_ADDR);
        repeat (4) begin cyc(1'b0); check("ldto_wait", obs, LD_MEM); end
        cyc(1'b1); check("ldto_error", obs, ERR_TO);
        rst_req = 1'b1;
        cyc(1'b0); check("ldto_rst_cycle", obs, ERR_TO);
        rst_req = 1'b0;
        opcode = 5'h0A;
        cyc(1'b1); check("abort_fetch", obs, FETCH_RDY);
        cyc(1'b1); check("abort_decode", obs, DEC);
        cyc(1'b1); check("abort_exec", obs, EXEC_ADDR);
        cyc(1'b0); check("abort_wait", obs, ST_WAIT);
        rst_req = 1'b1;
        cyc(1'b1); check("st_abort", obs, ST_ABORT);
        rst_req = 1'b0;
        cyc(1'b1); check("st_after_rst", obs, FETCH_RDY);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
